// File: rtl/ram_cache_pkg.sv
// Shared definitions for the 2-way write-through cache: FSM encodings, dataType codes,
// and the byte-lane helpers used on both the store and the load path.
package ram_cache_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REFILL = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;
  localparam logic [1:0] ST_WRITE  = 2'd3;

  localparam logic [1:0] DT_WORD     = 2'b00;
  localparam logic [1:0] DT_BYTE     = 2'b01;
  localparam logic [1:0] DT_HALF     = 2'b10;
  localparam logic [1:0] DT_WORD_ALT = 2'b11;

  function automatic logic [3:0] lane_enable(input logic [1:0] dt, input logic [1:0] boff);
    logic [3:0] be;
    case (dt)
      DT_BYTE: be = 4'b0001 << boff;
      DT_HALF: be = boff[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Moves right-aligned store data into the lanes selected by lane_enable; other lanes read 0.
  function automatic logic [31:0] place_data(input logic [1:0] dt, input logic [1:0] boff,
                                             input logic [31:0] wd);
    logic [31:0] placed;
    case (dt)
      DT_BYTE: placed = {24'h000000, wd[7:0]} << {boff, 3'b000};
      DT_HALF: placed = boff[1] ? {wd[15:0], 16'h0000} : {16'h0000, wd[15:0]};
      default: placed = wd;
    endcase
    return placed;
  endfunction

  function automatic logic [31:0] load_extract(input logic [1:0] dt, input logic [1:0] boff,
                                               input logic [31:0] word);
    logic [31:0] shifted;
    logic [31:0] result;
    shifted = word >> {boff, 3'b000};
    case (dt)
      DT_BYTE: result = {24'h000000, shifted[7:0]};
      DT_HALF: result = boff[1] ? {16'h0000, word[31:16]} : {16'h0000, word[15:0]};
      default: result = word;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/ram_cache_way.sv
// One way of the cache: per-set valid bit and tag, plus the line data words.
// Reads are asynchronous; data writes are per-word with byte enables.
module ram_cache_way
  import ram_cache_pkg::*;
#(
  parameter int SETS        = 16,
  parameter int BLOCK_WORDS = 4,
  parameter int TAG_W       = 24,
  parameter int IDX_W       = $clog2(SETS),
  parameter int OFF_W       = $clog2(BLOCK_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [OFF_W-1:0] rd_off,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [OFF_W-1:0] wr_off,
  input  logic [3:0]       wr_be,
  input  logic [31:0]      wr_data,
  input  logic             fill_en,
  input  logic [IDX_W-1:0] fill_idx,
  input  logic [TAG_W-1:0] fill_tag
);

  logic [SETS-1:0]  valid_q;
  logic [SETS-1:0]  valid_d;
  logic [TAG_W-1:0] tag_mem  [SETS];
  logic [31:0]      data_mem [SETS*BLOCK_WORDS];

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[{rd_idx, rd_off}];

  // Next valid vector: a completed fill marks its set valid.
  always_comb begin
    valid_d = valid_q;
    if (fill_en) begin
      valid_d[fill_idx] = 1'b1;
    end else begin
      valid_d = valid_q;
    end
  end

  // Valid bits are the only state cleared by reset; tags and data stay as RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= {SETS{1'b0}};
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag array write at line install.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[fill_idx] <= fill_tag;
    end
  end

  // Byte-enabled word write: untouched lanes keep their previous contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) begin
          data_mem[{wr_idx, wr_off}][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/ram_cache_assoc.sv
// 2-way set-associative write-through data cache with LRU replacement and word-by-word refill.
// Define RAM_CACHE_STATS_EN to add saturating hit_count / miss_count outputs for loads.
module ram_cache_assoc
  import ram_cache_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int SETS        = 16,
  parameter int BLOCK_WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  WE,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic [1:0]            dataType,
  input  logic [31:0]           WD,
  output logic [31:0]           RD,
  output logic                  ready,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ack
`ifdef RAM_CACHE_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  localparam int OFF_W  = $clog2(BLOCK_WORDS);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_WIDTH - 2 - OFF_W - IDX_W;
  localparam int LINE_W = ADDR_WIDTH - 2 - OFF_W;

  logic [1:0]        state_q, state_d;
  logic [OFF_W-1:0]  beat_q, beat_d;
  logic              victim_q, victim_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [SETS-1:0]   lru_q, lru_d;

  logic [OFF_W-1:0]  cpu_off;
  logic [IDX_W-1:0]  cpu_idx;
  logic [TAG_W-1:0]  cpu_tag;
  logic [TAG_W-1:0]  line_tag;
  logic [3:0]        cpu_be;
  logic [31:0]       cpu_wdata;

  logic [1:0]        way_valid;
  logic [TAG_W-1:0]  way_tag  [2];
  logic [31:0]       way_data [2];
  logic [1:0]        way_hit;
  logic              hit;
  logic [1:0]        way_wr_en;
  logic [1:0]        way_fill_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [OFF_W-1:0]  wr_off;
  logic [3:0]        wr_be;
  logic [31:0]       wr_data;

  assign cpu_off   = A[OFF_W+1:2];
  assign cpu_idx   = A[OFF_W+2 +: IDX_W];
  assign cpu_tag   = A[ADDR_WIDTH-1 -: TAG_W];
  assign line_tag  = line_q[LINE_W-1 -: TAG_W];
  assign cpu_be    = lane_enable(dataType, A[1:0]);
  assign cpu_wdata = place_data(dataType, A[1:0], WD);

  for (genvar w = 0; w < 2; w++) begin : g_way
    ram_cache_way #(
      .SETS        (SETS),
      .BLOCK_WORDS (BLOCK_WORDS),
      .TAG_W       (TAG_W)
    ) u_way (
      .clk      (clk),
      .rst      (rst),
      .rd_idx   (cpu_idx),
      .rd_off   (cpu_off),
      .rd_valid (way_valid[w]),
      .rd_tag   (way_tag[w]),
      .rd_data  (way_data[w]),
      .wr_en    (way_wr_en[w]),
      .wr_idx   (wr_idx),
      .wr_off   (wr_off),
      .wr_be    (wr_be),
      .wr_data  (wr_data),
      .fill_en  (way_fill_en[w]),
      .fill_idx (wr_idx),
      .fill_tag (line_tag)
    );
    assign way_hit[w] = way_valid[w] && (way_tag[w] == cpu_tag);
  end

  assign hit = |way_hit;

  // FSM next state, way write control and all CPU/memory-facing outputs.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    victim_d    = victim_q;
    line_d      = line_q;
    lru_d       = lru_q;
    ready       = 1'b0;
    RD          = 32'h0000_0000;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = {ADDR_WIDTH{1'b0}};
    mem_be      = 4'b0000;
    mem_wdata   = 32'h0000_0000;
    way_wr_en   = 2'b00;
    way_fill_en = 2'b00;
    wr_idx      = cpu_idx;
    wr_off      = cpu_off;
    wr_be       = cpu_be;
    wr_data     = cpu_wdata;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (WE) begin
            state_d = ST_WRITE;
            if (hit) begin
              way_wr_en      = way_hit;
              lru_d[cpu_idx] = way_hit[0];
            end else begin
              way_wr_en = 2'b00;
            end
          end else if (hit) begin
            ready          = 1'b1;
            RD             = load_extract(dataType, A[1:0], way_hit[1] ? way_data[1] : way_data[0]);
            lru_d[cpu_idx] = way_hit[0];
          end else begin
            // Fill an empty way before evicting; way 0 wins when both are empty.
            if (!way_valid[0]) begin
              victim_d = 1'b0;
            end else if (!way_valid[1]) begin
              victim_d = 1'b1;
            end else begin
              victim_d = lru_q[cpu_idx];
            end
            line_d  = A[ADDR_WIDTH-1:OFF_W+2];
            beat_d  = {OFF_W{1'b0}};
            state_d = ST_REFILL;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {line_q, beat_q, 2'b00};
        wr_idx   = line_q[IDX_W-1:0];
        wr_off   = beat_q;
        wr_be    = 4'b1111;
        wr_data  = mem_rdata;
        if (mem_ack) begin
          way_wr_en[victim_q] = 1'b1;
          beat_d              = beat_q + OFF_W'(1);
          if (beat_q == OFF_W'(BLOCK_WORDS - 1)) begin
            way_fill_en[victim_q]     = 1'b1;
            lru_d[line_q[IDX_W-1:0]]  = ~victim_q;
            beat_d                    = {OFF_W{1'b0}};
            state_d                   = ST_RESP;
          end else begin
            state_d = ST_REFILL;
          end
        end else begin
          state_d = ST_REFILL;
        end
      end
      ST_RESP: begin
        ready   = 1'b1;
        RD      = load_extract(dataType, A[1:0], victim_q ? way_data[1] : way_data[0]);
        state_d = ST_IDLE;
      end
      ST_WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {A[ADDR_WIDTH-1:2], 2'b00};
        mem_be    = cpu_be;
        mem_wdata = cpu_wdata;
        if (mem_ack) begin
          ready   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WRITE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      beat_q   <= {OFF_W{1'b0}};
      victim_q <= 1'b0;
      line_q   <= {LINE_W{1'b0}};
      lru_q    <= {SETS{1'b0}};
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      victim_q <= victim_d;
      line_q   <= line_d;
      lru_q    <= lru_d;
    end
  end

`ifdef RAM_CACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic        hit_evt;
  logic        miss_evt;

  assign hit_evt  = (state_q == ST_IDLE) && req_valid && !WE && hit;
  assign miss_evt = (state_q == ST_IDLE) && req_valid && !WE && !hit;

  // Saturating load hit/miss counters.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit_evt && (hit_cnt_q != 32'hFFFF_FFFF)) begin
      hit_cnt_d = hit_cnt_q + 32'd1;
    end else begin
      hit_cnt_d = hit_cnt_q;
    end
    if (miss_evt && (miss_cnt_q != 32'hFFFF_FFFF)) begin
      miss_cnt_d = miss_cnt_q + 32'd1;
    end else begin
      miss_cnt_d = miss_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= 32'h0000_0000;
      miss_cnt_q <= 32'h0000_0000;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_ram_cache_assoc.sv
// Scoreboard bench for ram_cache_assoc: a behavioural backing memory doubles as the
// reference store; expected load data is queued at request time and popped at ready.
module tb_ram_cache_assoc;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        WE;
  logic [31:0] A;
  logic [1:0]  dataType;
  logic [31:0] WD;
  logic [31:0] RD;
  logic        ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
`ifdef RAM_CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  logic        ack_en;
  logic        init_req;
  logic [31:0] mem [0:2047];
  int          n_checks = 0;
  int          n_pass = 0;
  int          rd_total = 0;
  int          rd_start = 0;
  logic [31:0] exp_line = 32'h0;
  logic [31:0] exp_q [$];
  logic        saw_req;
  logic [3:0]  last_be;
  logic [31:0] last_wdata;

  always #5 clk = ~clk;

  ram_cache_assoc #(.ADDR_WIDTH(32), .SETS(16), .BLOCK_WORDS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .WE        (WE),
    .A         (A),
    .dataType  (dataType),
    .WD        (WD),
    .RD        (RD),
    .ready     (ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
`ifdef RAM_CACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  function automatic int midx(input logic [31:0] a);
    return int'({a[18:16], a[9:2]});
  endfunction

  assign mem_ack   = mem_req & ack_en;
  assign mem_rdata = mem[midx(mem_addr)];

  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 32'h9E37_79B9 ^ (i * 32'h0100_0193);
      mem[midx(32'h0001_0000)] <= 32'h1122_3344;
      mem[midx(32'h0001_0008)] <= 32'hCAFE_BABE;
    end else if (mem_req && mem_we && mem_ack) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[midx(mem_addr)][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // Refill beats: an acked read seen at negedge completes at the next posedge.
  always @(negedge clk) begin
    if (!rst && mem_req && !mem_we && mem_ack) begin
      check_eq("beat_addr", mem_addr, exp_line + 32'((rd_total - rd_start) * 4));
      rd_total <= rd_total + 1;
    end
  end

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] dt);
    logic [31:0] w;
    w = mem[midx(addr)];
    if (dt == 2'b01) return (w >> (8 * addr[1:0])) & 32'h0000_00FF;
    if (dt == 2'b10) return (w >> (16 * addr[1])) & 32'h0000_FFFF;
    return w;
  endfunction

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] dt,
                        input logic [31:0] wd, input int exp_reads, input int exp_cycles);
    int cyc;
    logic done;
    exp_q.push_back(we ? 32'h0 : model_load(addr, dt));
    exp_line = {addr[31:4], 4'h0};
    rd_start = rd_total;
    saw_req  = 1'b0;
    req_valid = 1'b1; WE = we; A = addr; dataType = dt; WD = wd;
    cyc = 0; done = 1'b0;
    while (!done && cyc < 40) begin
      #1;
      cyc++;
      if (mem_req) saw_req = 1'b1;
      if (ready) begin
        done = 1'b1;
        check_eq("rd", RD, exp_q.pop_front());
        last_be = mem_be;
        last_wdata = mem_wdata;
      end
      @(negedge clk);
    end
    req_valid = 1'b0; WE = 1'b0;
    check_eq("ready_seen", {31'h0, done}, 32'h1);
    if (!done) void'(exp_q.pop_front());
    if (exp_cycles > 0) check_eq("latency", cyc, exp_cycles);
    check_eq("refill_beats", rd_total - rd_start, exp_reads);
  endtask

  initial begin
    rst = 1'b1; init_req = 1'b1; ack_en = 1'b1;
    req_valid = 1'b0; WE = 1'b0; A = 32'h0; dataType = 2'b00; WD = 32'h0;
    @(negedge clk); @(negedge clk);
    check_eq("rst_ready", {31'h0, ready}, 32'h0);
    check_eq("rst_rd", RD, 32'h0);
    check_eq("rst_mem_req", {31'h0, mem_req}, 32'h0);
    check_eq("rst_mem_we", {31'h0, mem_we}, 32'h0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_mem_be", {28'h0, mem_be}, 32'h0);
    check_eq("rst_mem_wdata", mem_wdata, 32'h0);
    init_req = 1'b0; rst = 1'b0;
    @(negedge clk);

    do_req(1'b0, 32'h0001_0000, 2'b00, 32'h0, 4, 6);
    do_req(1'b0, 32'h0001_0008, 2'b00, 32'h0, 0, 1);
    check_eq("hit_no_mem_req", {31'h0, saw_req}, 32'h0);

    do_req(1'b1, 32'h0001_0001, 2'b01, 32'h0000_00AB, 0, 2);
    check_eq("byte_be", {28'h0, last_be}, 32'h2);
    check_eq("byte_wdata", last_wdata, 32'h0000_AB00);
    check_eq("mem_merge", mem[midx(32'h0001_0000)], 32'h1122_AB44);
    do_req(1'b0, 32'h0001_0000, 2'b00, 32'h0, 0, 1);

    do_req(1'b1, 32'h0001_0006, 2'b10, 32'h1234_BEEF, 0, 2);
    check_eq("half_be", {28'h0, last_be}, 32'hC);
    check_eq("half_wdata", last_wdata, 32'hBEEF_0000);
    do_req(1'b0, 32'h0001_0004, 2'b00, 32'h0, 0, 1);

    do_req(1'b0, 32'h0002_0000, 2'b00, 32'h0, 4, 6);
    do_req(1'b0, 32'h0001_0000, 2'b00, 32'h0, 0, 1);
    do_req(1'b0, 32'h0003_0000, 2'b00, 32'h0, 4, 6);
    do_req(1'b0, 32'h0001_0000, 2'b00, 32'h0, 0, 1);
    do_req(1'b0, 32'h0002_0000, 2'b00, 32'h0, 4, 6);

    do_req(1'b0, 32'h0001_000A, 2'b10, 32'h0, 0, 1);
    do_req(1'b0, 32'h0001_000B, 2'b01, 32'h0, 0, 1);
    do_req(1'b0, 32'h0001_0009, 2'b01, 32'h0, 0, 1);
    do_req(1'b0, 32'h0001_000A, 2'b11, 32'h0, 0, 1);

    do_req(1'b1, 32'h0005_0000, 2'b00, 32'hDEAD_BEEF, 0, 2);
    do_req(1'b0, 32'h0005_0000, 2'b00, 32'h0, 4, 6);

    // Reset during a stalled refill after two beats.
    exp_line = 32'h0007_0000;
    rd_start = rd_total;
    req_valid = 1'b1; WE = 1'b0; A = 32'h0007_0004; dataType = 2'b00;
    for (int i = 0; i < 20 && (rd_total - rd_start) < 2; i++) begin
      @(negedge clk); #1;
    end
    @(posedge clk); #1;
    ack_en = 1'b0;
    @(negedge clk); @(negedge clk);
    check_eq("stall_mem_req", {31'h0, mem_req}, 32'h1);
    rst = 1'b1;
    #1;
    check_eq("rst_drop_req", {31'h0, mem_req}, 32'h0);
    check_eq("rst_drop_addr", mem_addr, 32'h0);
    req_valid = 1'b0;
    ack_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_req(1'b0, 32'h0007_0004, 2'b00, 32'h0, 4, 6);
    do_req(1'b0, 32'h0001_0000, 2'b00, 32'h0, 4, 6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
